action_arbiter: RTL and testbench

ACTION_ARBITER -- requirements
Module: action_arbiter

---
 rtl/overcooked_pkg.sv | 57 +++++
 rtl/rr_arbiter4.sv | 35 +++
 rtl/action_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_action_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/overcooked_pkg.sv
// -----------------------------------------------------------------------------
// overcooked_pkg
// Shared constants and types for the kitchen action arbiter.
//   GS_*          : global game state codes driven by the game controller
//   OP_*          : per-player operation codes (code 3 behaves like OP_NONE)
//   CHOP_FRAMES   : frames a cutting station stays busy after a chop starts
//   NUM_STATIONS  : number of cutting stations on the 8x13 grid
//   STATION_ROW/COL : fixed grid cell of each station, indexed by station
//   state_e       : arbiter FSM states
// -----------------------------------------------------------------------------
package overcooked_pkg;

    localparam logic [2:0] GS_PLAY  = 3'd2;
    localparam logic [2:0] GS_PAUSE = 3'd3;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_CARRY = 2'd1;
    localparam logic [1:0] OP_CHOP  = 2'd2;

    localparam logic [3:0] CHOP_FRAMES  = 4'd15;
    localparam int         NUM_STATIONS = 6;

    // Station k sits at (STATION_ROW[k], STATION_COL[k]); entries listed 5..0.
    // Stations 0..3 line the top counter, 4..5 the bottom counter.
    localparam logic [NUM_STATIONS-1:0][2:0] STATION_ROW = {
        3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0
    };
    localparam logic [NUM_STATIONS-1:0][3:0] STATION_COL = {
        4'd8, 4'd4, 4'd10, 4'd8, 4'd4, 4'd2
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    // One-hot station index whose cell equals (row, col); zero when the cell
    // is not a station. Station cells are unique, so at most one bit is set.
    function automatic logic [NUM_STATIONS-1:0] stationMatch(
        input logic [2:0] row,
        input logic [3:0] col
    );
        logic [NUM_STATIONS-1:0] hit;
        hit = '0;
        for (int k = 0; k < NUM_STATIONS; k++) begin
            hit[k] = (STATION_ROW[k] == row) && (STATION_COL[k] == col);
        end
        return hit;
    endfunction

    // Only CARRY and CHOP ask for arbitration; NONE and the unused code 3 do not.
    function automatic logic isActionOp(input logic [1:0] op);
        return (op == OP_CARRY) || (op == OP_CHOP);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Four-way round-robin picker with a variable number of active lanes.
//   req    [3:0] in  : lane requests (already qualified by the caller)
//   limit  [1:0] in  : highest active lane index; lanes above it are ignored
//   ptr    [1:0] in  : lane where the search starts; treated as 0 when > limit
//   winner [1:0] out : index of the first requesting lane at or after ptr,
//                      wrapping from limit back to 0
//   valid        out : a winner was found
// -----------------------------------------------------------------------------
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] limit,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       valid
);

    // Walk the ring of active lanes once, starting at the (clamped) pointer,
    // and keep the first requester found. Four steps cover the largest ring.
    always_comb begin
        logic [1:0] cand;
        winner = 2'd0;
        valid  = 1'b0;
        cand   = (ptr > limit) ? 2'd0 : ptr;
        for (int k = 0; k < 4; k++) begin
            if (!valid && req[cand] && (cand <= limit)) begin
                winner = cand;
                valid  = 1'b1;
            end
            cand = (cand == limit) ? 2'd0 : cand + 2'd1;
        end
    end

endmodule

// File: rtl/action_arbiter.sv
// -----------------------------------------------------------------------------
// action_arbiter
// Once per video frame, picks at most one player action (carry or chop) in
// round-robin order, grants or denies it, and runs the chop countdown of each
// cutting station.
//   vsync        in  : frame tick, the only clock
//   reset        in  : synchronous, active-high
//   num_players  in  : active players minus 1 (players 0..num_players active)
//   game_state   in  : GS_PLAY runs, GS_PAUSE freezes, anything else idles
//   req          in  : per-player request level, held until grant or deny
//   req_op       in  : per-player operation code
//   req_row/col  in  : per-player target grid cell
//   grant/deny   out : one-hot pulses, at most one bit of grant|deny per frame
//   grant_op/row/col out : operation and cell of the current grant, else 0
//   time_grid    out : per-station chop countdown
//   chop_done    out : per-station pulse in the frame a countdown hits 0
// -----------------------------------------------------------------------------
import overcooked_pkg::*;

module action_arbiter (
    input  logic                               vsync,
    input  logic                               reset,
    input  logic [1:0]                         num_players,
    input  logic [2:0]                         game_state,
    input  logic [3:0]                         req,
    input  logic [3:0][1:0]                    req_op,
    input  logic [3:0][2:0]                    req_row,
    input  logic [3:0][3:0]                    req_col,
    output logic [3:0]                         grant,
    output logic [3:0]                         deny,
    output logic [1:0]                         grant_op,
    output logic [2:0]                         grant_row,
    output logic [3:0]                         grant_col,
    output logic [NUM_STATIONS-1:0][3:0]       time_grid,
    output logic [NUM_STATIONS-1:0]            chop_done
);

    state_e state_q, state_d;
    logic   runEn;
    logic   clearEn;

    logic [1:0]                   ptr_q, ptr_d;
    logic [3:0]                   served_q, served_d;
    logic [NUM_STATIONS-1:0][3:0] time_q, time_d;
    logic [NUM_STATIONS-1:0]      done_q, done_d;
    logic [3:0]                   grant_q, grant_d;
    logic [3:0]                   deny_q, deny_d;
    logic [1:0]                   gop_q, gop_d;
    logic [2:0]                   grow_q, grow_d;
    logic [3:0]                   gcol_q, gcol_d;

    logic [3:0]              eligible;
    logic [1:0]              winIdx;
    logic                    winValid;
    logic [1:0]              winOp;
    logic [2:0]              winRow;
    logic [3:0]              winCol;
    logic [NUM_STATIONS-1:0] stationHit;
    logic [NUM_STATIONS-1:0] timerBusy;
    logic                    doGrant;
    logic                    doDeny;
    logic [NUM_STATIONS-1:0] loadVec;
    logic [3:0]              winOneHot;

    // FSM state register; reset always lands in S_IDLE.
    always_ff @(posedge vsync) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The game controller owns the mode: the next state follows game_state
    // directly on every frame, whatever the current state.
    always_comb begin
        state_d = S_IDLE;
        if (game_state == GS_PLAY) begin
            state_d = S_RUN;
        end else if (game_state == GS_PAUSE) begin
            state_d = S_PAUSE;
        end
    end

    // Mode decode for the datapath; S_PAUSE is simply neither run nor clear.
    always_comb begin
        runEn   = 1'b0;
        clearEn = 1'b0;
        case (state_q)
            S_RUN:   runEn   = 1'b1;
            S_IDLE:  clearEn = 1'b1;
            default: ;
        endcase
    end

    // A player competes only if active, asking for a real action, and not the
    // one served last frame (its req is still high while it sees the pulse).
    always_comb begin
        eligible = '0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = req[i] && (2'(i) <= num_players) &&
                          isActionOp(req_op[i]) && !served_q[i];
        end
    end

    rr_arbiter4 u_rr (
        .req    (eligible),
        .limit  (num_players),
        .ptr    (ptr_q),
        .winner (winIdx),
        .valid  (winValid)
    );

    // Any action on a station that is still counting is refused; a chop on an
    // idle station starts its countdown.
    always_comb begin
        winOp      = req_op[winIdx];
        winRow     = req_row[winIdx];
        winCol     = req_col[winIdx];
        winOneHot  = 4'b0001 << winIdx;
        stationHit = stationMatch(winRow, winCol);
        for (int k = 0; k < NUM_STATIONS; k++) begin
            timerBusy[k] = (time_q[k] != 4'd0);
        end
        doDeny  = winValid && runEn && ((stationHit & timerBusy) != '0);
        doGrant = winValid && runEn && !doDeny;
        loadVec = (doGrant && (winOp == OP_CHOP)) ? stationHit : '0;
    end

    // Next-state datapath. Pulses default to 0 every frame; timers and the
    // pointer hold unless the mode says otherwise.
    always_comb begin
        ptr_d    = ptr_q;
        time_d   = time_q;
        served_d = '0;
        done_d   = '0;
        grant_d  = '0;
        deny_d   = '0;
        gop_d    = '0;
        grow_d   = '0;
        gcol_d   = '0;
        if (clearEn) begin
            ptr_d  = 2'd0;
            time_d = '0;
        end else if (runEn) begin
            for (int k = 0; k < NUM_STATIONS; k++) begin
                if (loadVec[k]) begin
                    time_d[k] = CHOP_FRAMES;
                end else if (time_q[k] != 4'd0) begin
                    time_d[k] = time_q[k] - 4'd1;
                    done_d[k] = (time_q[k] == 4'd1);
                end
            end
            if (winValid) begin
                served_d = winOneHot;
                ptr_d    = (winIdx == num_players) ? 2'd0 : winIdx + 2'd1;
            end
            if (doGrant) begin
                grant_d = winOneHot;
                gop_d   = winOp;
                grow_d  = winRow;
                gcol_d  = winCol;
            end
            if (doDeny) begin
                deny_d = winOneHot;
            end
        end
    end

    // Registered state and outputs; reset wins over anything in flight.
    always_ff @(posedge vsync) begin
        if (reset) begin
            ptr_q    <= '0;
            served_q <= '0;
            time_q   <= '0;
            done_q   <= '0;
            grant_q  <= '0;
            deny_q   <= '0;
            gop_q    <= '0;
            grow_q   <= '0;
            gcol_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            served_q <= served_d;
            time_q   <= time_d;
            done_q   <= done_d;
            grant_q  <= grant_d;
            deny_q   <= deny_d;
            gop_q    <= gop_d;
            grow_q   <= grow_d;
            gcol_q   <= gcol_d;
        end
    end

    assign grant     = grant_q;
    assign deny      = deny_q;
    assign grant_op  = gop_q;
    assign grant_row = grow_q;
    assign grant_col = gcol_q;
    assign time_grid = time_q;
    assign chop_done = done_q;

endmodule

// File: tb/tb_action_arbiter.sv
// -----------------------------------------------------------------------------
// tb_action_arbiter
// Drives directed scenarios followed by random frames into action_arbiter.
// A frame-level reference model predicts each frame's outputs into a queue;
// an independent monitor pops one prediction per frame and compares.
// -----------------------------------------------------------------------------
module tb_action_arbiter;

    logic             vsync = 1'b0;
    logic             reset;
    logic [1:0]       num_players;
    logic [2:0]       game_state;
    logic [3:0]       req;
    logic [3:0][1:0]  req_op;
    logic [3:0][2:0]  req_row;
    logic [3:0][3:0]  req_col;
    logic [3:0]       grant;
    logic [3:0]       deny;
    logic [1:0]       grant_op;
    logic [2:0]       grant_row;
    logic [3:0]       grant_col;
    logic [5:0][3:0]  time_grid;
    logic [5:0]       chop_done;

    typedef struct packed {
        logic [3:0]      grant;
        logic [3:0]      deny;
        logic [1:0]      gop;
        logic [2:0]      grow;
        logic [3:0]      gcol;
        logic [5:0][3:0] tg;
        logic [5:0]      done;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state: mode 0 idle, 1 running, 2 paused.
    int         mMode = 0;
    int         mPtr  = 0;
    int         mTimer[6];
    logic [3:0] mServed = '0;
    logic [3:0] prevServed = '0;

    // Station cells, independently transcribed from the station layout.
    int stRow[6] = '{0, 0, 0, 0, 7, 7};
    int stCol[6] = '{2, 4, 8, 10, 4, 8};

    action_arbiter dut (
        .vsync       (vsync),
        .reset       (reset),
        .num_players (num_players),
        .game_state  (game_state),
        .req         (req),
        .req_op      (req_op),
        .req_row     (req_row),
        .req_col     (req_col),
        .grant       (grant),
        .deny        (deny),
        .grant_op    (grant_op),
        .grant_row   (grant_row),
        .grant_col   (grant_col),
        .time_grid   (time_grid),
        .chop_done   (chop_done)
    );

    always #10 vsync = ~vsync;

    // Predicts what the DUT shows after the coming edge, given current inputs.
    task automatic modelStep(output exp_t e);
        int limit;
        int start;
        int winner;
        int st;
        int nt[6];
        e = '0;
        if (reset) begin
            mMode   = 0;
            mPtr    = 0;
            mServed = '0;
            for (int k = 0; k < 6; k++) mTimer[k] = 0;
        end else begin
            if (mMode == 0) begin
                mPtr    = 0;
                mServed = '0;
                for (int k = 0; k < 6; k++) mTimer[k] = 0;
            end else if (mMode == 2) begin
                mServed = '0;
            end else begin
                limit  = int'(num_players);
                start  = (mPtr > limit) ? 0 : mPtr;
                winner = -1;
                for (int k = 0; k <= limit; k++) begin
                    int c;
                    c = (start + k) % (limit + 1);
                    if (winner < 0 && req[c] && (req_op[c] == 2'd1 || req_op[c] == 2'd2)
                        && !mServed[c]) winner = c;
                end
                for (int k = 0; k < 6; k++) begin
                    nt[k] = (mTimer[k] > 0) ? mTimer[k] - 1 : 0;
                    if (mTimer[k] == 1) e.done[k] = 1'b1;
                end
                mServed = '0;
                if (winner >= 0) begin
                    st = -1;
                    for (int k = 0; k < 6; k++) begin
                        if (int'(req_row[winner]) == stRow[k] && int'(req_col[winner]) == stCol[k]) st = k;
                    end
                    mServed[winner] = 1'b1;
                    mPtr = (winner + 1) % (limit + 1);
                    if (st >= 0 && mTimer[st] != 0) begin
                        e.deny[winner] = 1'b1;
                    end else begin
                        e.grant[winner] = 1'b1;
                        e.gop  = req_op[winner];
                        e.grow = req_row[winner];
                        e.gcol = req_col[winner];
                        if (req_op[winner] == 2'd2 && st >= 0) nt[st] = 15;
                    end
                end
                for (int k = 0; k < 6; k++) mTimer[k] = nt[k];
            end
            mMode = (game_state == 3'd2) ? 1 : (game_state == 3'd3) ? 2 : 0;
        end
        for (int k = 0; k < 6; k++) e.tg[k] = 4'(mTimer[k]);
    endtask

    // One frame: retire requests served last frame, predict, advance a frame.
    task automatic applyStimulus();
        exp_t e;
        req = req & ~prevServed;
        modelStep(e);
        expQ.push_back(e);
        prevServed = e.grant | e.deny;
        @(negedge vsync);
    endtask

    task automatic setReq(input int p, input logic [1:0] op, input int r, input int c);
        req_op[p]  = op;
        req_row[p] = 3'(r);
        req_col[p] = 4'(c);
        req[p]     = 1'b1;
    endtask

    task automatic checkOutput();
        exp_t e;
        compared++;
        if ($countones(grant | deny) > 1) begin
            mismatched++;
            $display("[TB] FAIL onehot: grant=%b deny=%b, required at most one bit", grant, deny);
        end
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard: DUT output at %0t with no prediction queued", $time);
        end else begin
            e = expQ.pop_front();
            if (grant !== e.grant || deny !== e.deny || grant_op !== e.gop ||
                grant_row !== e.grow || grant_col !== e.gcol ||
                time_grid !== e.tg || chop_done !== e.done) begin
                mismatched++;
                $display("[TB] FAIL frame@%0t: got grant=%b deny=%b op=%0d row=%0d col=%0d tg=%h done=%b; expected grant=%b deny=%b op=%0d row=%0d col=%0d tg=%h done=%b",
                         $time, grant, deny, grant_op, grant_row, grant_col, time_grid, chop_done,
                         e.grant, e.deny, e.gop, e.grow, e.gcol, e.tg, e.done);
            end
        end
    endtask

    // Monitor: one DUT output frame per edge, sampled just after the edge.
    initial begin
        forever begin
            @(posedge vsync);
            #1;
            checkOutput();
        end
    end

    // Stimulus: directed scenarios, then randomized frames.
    initial begin
        int r;
        for (int k = 0; k < 6; k++) mTimer[k] = 0;
        reset       = 1'b1;
        num_players = 2'd1;
        game_state  = 3'd2;
        req         = '0;
        req_op      = '0;
        req_row     = '0;
        req_col     = '0;
        repeat (3) applyStimulus();
        reset = 1'b0;
        repeat (2) applyStimulus();

        $display("[TB] two players contend in the same frame");
        setReq(0, 2'd1, 0, 0);
        setReq(1, 2'd1, 1, 1);
        repeat (4) applyStimulus();

        $display("[TB] full chop on station 0");
        setReq(0, 2'd2, 0, 2);
        repeat (18) applyStimulus();

        $display("[TB] carry onto a busy station");
        setReq(0, 2'd2, 0, 2);
        repeat (7) applyStimulus();
        setReq(1, 2'd1, 0, 2);
        repeat (12) applyStimulus();

        $display("[TB] inactive player holds a chop request");
        setReq(3, 2'd2, 7, 4);
        repeat (20) applyStimulus();
        req[3] = 1'b0;

        $display("[TB] pause, resume and idle mid-chop");
        setReq(0, 2'd2, 0, 2);
        repeat (9) applyStimulus();
        game_state = 3'd3;
        repeat (5) applyStimulus();
        game_state = 3'd2;
        repeat (4) applyStimulus();
        game_state = 3'd0;
        repeat (3) applyStimulus();
        game_state = 3'd2;
        repeat (2) applyStimulus();

        $display("[TB] reset during chop with a request pending");
        setReq(0, 2'd2, 0, 2);
        repeat (6) applyStimulus();
        setReq(1, 2'd1, 3, 3);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        req   = '0;
        repeat (3) applyStimulus();

        $display("[TB] randomized frames");
        for (int cyc = 0; cyc < 2000; cyc++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) num_players = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) begin
                r = $urandom_range(0, 99);
                game_state = (r < 75) ? 3'd2 : (r < 88) ? 3'd3 : 3'($urandom_range(0, 7));
            end
            for (int p = 0; p < 4; p++) begin
                if (!req[p] && $urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 9);
                    req_op[p] = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 0) begin
                        r = $urandom_range(0, 5);
                        req_row[p] = 3'(stRow[r]);
                        req_col[p] = 4'(stCol[r]);
                    end else begin
                        req_row[p] = 3'($urandom_range(0, 7));
                        req_col[p] = 4'($urandom_range(0, 12));
                    end
                    req[p] = 1'b1;
                end else if (req[p] && (2'(p) > num_players || req_op[p] == 2'd0 || req_op[p] == 2'd3)
                             && $urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end
            end
            applyStimulus();
        end

        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
